// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared game-state encoding, decoded by the sequencer, drawing and score blocks.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAYING   = 3'd1,
    LOST_ANIM = 3'd2,
    WIN_ANIM  = 3'd3,
    GAME_OVER = 3'd4,
    PAUSED    = 3'd5
  } state_t;

  function automatic logic isAnimState(input state_t s);
    return (s == LOST_ANIM) || (s == WIN_ANIM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_countdown.sv
`default_nettype none
// ============================================================================
// Module   : frame_countdown
// Purpose  : Loadable down-counter that steps once per frame tick and stops at zero.
// Revision : 1.0 - initial release
// ============================================================================
module frame_countdown #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             enable,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             nonZero
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_nextCount;
  logic             r_nonZero;

  always_comb begin
    w_nextCount = r_count;
    if (clear) begin
      w_nextCount = '0;
    end else if (load) begin
      w_nextCount = loadValue;
    end else if (enable && tick && (r_count != '0)) begin
      w_nextCount = r_count - WIDTH'(1);
    end
  end

  // nonZero is registered from the next value so it aligns with count
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count   <= '0;
      r_nonZero <= 1'b0;
    end else begin
      r_count   <= w_nextCount;
      r_nonZero <= (w_nextCount != '0);
    end
  end

  assign count   = r_count;
  assign nonZero = r_nonZero;

endmodule
`default_nettype wire

// File: rtl/game_flow_fsm.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_fsm
// Purpose  : Top-level game sequencer: state, gameplay gate, level reset pulse,
//            level index and hit-flash request. Define GAME_PAUSE_EN to add PAUSED.
// Revision : 1.0 - initial release
// ============================================================================
module game_flow_fsm
  import game_pkg::*;
#(
  parameter int ANIM_FRAMES  = 60,
  parameter int FLASH_FRAMES = 20,
  parameter int MAX_LEVEL    = 7,
  parameter int LEVEL_W      = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               startKey,
  input  logic               pauseKey,
  input  logic               lost,
  input  logic               allAliensDead,
  input  logic [1:0]         playerHealth,
  output state_t             gameState,
  output logic               gameplayEnable,
  output logic               levelResetN,
  output logic [LEVEL_W-1:0] level,
  output logic               hitFlash
);

  localparam int ANIM_W  = $clog2(ANIM_FRAMES + 1);
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

  state_t             r_state;
  state_t             w_nextState;
  logic               r_gameplayEnable;
  logic               r_levelResetN;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] w_nextLevel;
  logic               w_levelPulse;
  logic [1:0]         r_healthD;

  logic               r_startKeyD;
  logic               r_startArmed;
  logic               r_startEdge;

  logic [ANIM_W-1:0]  w_animCount;
  logic               w_animLoad;
  logic               w_animClear;
  logic               w_animEnable;
  logic               w_animDone;
  logic               w_unusedAnimNonZero;

  logic [FLASH_W-1:0] w_unusedFlashCount;
  logic               w_flashLoad;
  logic               w_flashClear;
  logic               w_flashEnable;
  logic               w_flashNonZero;

  // A key held through reset stays disarmed until it has been seen released
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_startKeyD  <= 1'b0;
      r_startArmed <= 1'b0;
      r_startEdge  <= 1'b0;
    end else begin
      r_startKeyD  <= startKey;
      r_startArmed <= r_startArmed | ~startKey;
      r_startEdge  <= startKey & ~r_startKeyD & r_startArmed;
    end
  end

`ifdef GAME_PAUSE_EN
  logic r_pauseKeyD;
  logic r_pauseArmed;
  logic r_pauseEdge;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pauseKeyD  <= 1'b0;
      r_pauseArmed <= 1'b0;
      r_pauseEdge  <= 1'b0;
    end else begin
      r_pauseKeyD  <= pauseKey;
      r_pauseArmed <= r_pauseArmed | ~pauseKey;
      r_pauseEdge  <= pauseKey & ~r_pauseKeyD & r_pauseArmed;
    end
  end
`else
  logic w_unusedPauseKey;
  assign w_unusedPauseKey = pauseKey;
`endif

  assign w_animDone = startOfFrame && (w_animCount == ANIM_W'(1));

  always_comb begin
    w_nextState  = r_state;
    w_nextLevel  = r_level;
    w_levelPulse = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_startEdge) begin
          w_nextState  = PLAYING;
          w_nextLevel  = '0;
          w_levelPulse = 1'b1;
        end
      end
      PLAYING: begin
        if (lost) begin
          w_nextState = LOST_ANIM;
        end else if (allAliensDead) begin
          w_nextState = WIN_ANIM;
`ifdef GAME_PAUSE_EN
        end else if (r_pauseEdge) begin
          w_nextState = PAUSED;
`endif
        end
      end
      LOST_ANIM: begin
        if (w_animDone) begin
          w_nextState = GAME_OVER;
        end
      end
      WIN_ANIM: begin
        if (w_animDone) begin
          w_nextState  = PLAYING;
          w_levelPulse = 1'b1;
          w_nextLevel  = (r_level == LEVEL_W'(MAX_LEVEL)) ? '0 : r_level + LEVEL_W'(1);
        end
      end
      GAME_OVER: begin
        if (r_startEdge) begin
          w_nextState = IDLE;
        end
      end
`ifdef GAME_PAUSE_EN
      PAUSED: begin
        if (r_pauseEdge) begin
          w_nextState = PLAYING;
        end
      end
`endif
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state          <= IDLE;
      r_gameplayEnable <= 1'b0;
      r_levelResetN    <= 1'b1;
      r_level          <= '0;
      r_healthD        <= 2'd0;
    end else begin
      r_state          <= w_nextState;
      r_gameplayEnable <= (w_nextState == PLAYING);
      r_levelResetN    <= ~w_levelPulse;
      r_level          <= w_nextLevel;
      r_healthD        <= playerHealth;
    end
  end

  // Animation timer reloads on entry to either animation, zeroes on any other entry
  assign w_animLoad   = (w_nextState != r_state) && isAnimState(w_nextState);
  assign w_animClear  = (w_nextState != r_state) && !isAnimState(w_nextState);
  assign w_animEnable = isAnimState(r_state);

  frame_countdown #(
    .WIDTH(ANIM_W)
  ) u_animTimer (
    .clk      (clk),
    .resetN   (resetN),
    .clear    (w_animClear),
    .load     (w_animLoad),
    .loadValue(ANIM_W'(ANIM_FRAMES)),
    .enable   (w_animEnable),
    .tick     (startOfFrame),
    .count    (w_animCount),
    .nonZero  (w_unusedAnimNonZero)
  );

  // Flash survives a trip into PAUSED (frozen) but not any other exit from PLAYING
  assign w_flashLoad   = (r_state == PLAYING) && (playerHealth < r_healthD);
  assign w_flashClear  = (r_state == PLAYING) && (w_nextState != PLAYING) && (w_nextState != PAUSED);
  assign w_flashEnable = (r_state == PLAYING);

  frame_countdown #(
    .WIDTH(FLASH_W)
  ) u_flashTimer (
    .clk      (clk),
    .resetN   (resetN),
    .clear    (w_flashClear),
    .load     (w_flashLoad),
    .loadValue(FLASH_W'(FLASH_FRAMES)),
    .enable   (w_flashEnable),
    .tick     (startOfFrame),
    .count    (w_unusedFlashCount),
    .nonZero  (w_flashNonZero)
  );

  assign gameState      = r_state;
  assign gameplayEnable = r_gameplayEnable;
  assign levelResetN    = r_levelResetN;
  assign level          = r_level;
  assign hitFlash       = w_flashNonZero;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_flow_fsm
// Purpose  : Directed vector table plus hand sequences for game_flow_fsm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_flow_fsm;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       startKey;
  logic       pauseKey;
  logic       lost;
  logic       allAliensDead;
  logic [1:0] playerHealth;
  state_t     gameState;
  logic       gameplayEnable;
  logic       levelResetN;
  logic [2:0] level;
  logic       hitFlash;

  int total = 0;
  int bad   = 0;

  game_flow_fsm #(
    .ANIM_FRAMES (60),
    .FLASH_FRAMES(20),
    .MAX_LEVEL   (7),
    .LEVEL_W     (3)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .startKey      (startKey),
    .pauseKey      (pauseKey),
    .lost          (lost),
    .allAliensDead (allAliensDead),
    .playerHealth  (playerHealth),
    .gameState     (gameState),
    .gameplayEnable(gameplayEnable),
    .levelResetN   (levelResetN),
    .level         (level),
    .hitFlash      (hitFlash)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       startKey;
    logic       lost;
    logic       dead;
    logic [1:0] health;
    logic       sof;
    state_t     st;
    logic       en;
    logic       lrn;
    logic [2:0] lvl;
    logic       hf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: a single-clock startOfFrame pulse followed by two quiet clocks
  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lows;
    logic [2:0] expLvl;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, IDLE,      1'b0, 1'b1, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b0, IDLE,      1'b0, 1'b1, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b0, PLAYING,   1'b1, 1'b0, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b0, PLAYING,   1'b1, 1'b1, 3'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd3, 1'b0, PLAYING,   1'b1, 1'b1, 3'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, PLAYING,   1'b1, 1'b1, 3'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b0, PLAYING,   1'b1, 1'b1, 3'd0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, PLAYING,   1'b1, 1'b1, 3'd0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0, LOST_ANIM, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, LOST_ANIM, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, LOST_ANIM, 1'b0, 1'b1, 3'd0, 1'b0};

    resetN = 1'b0; startOfFrame = 1'b0; startKey = 1'b0; pauseKey = 1'b0;
    lost = 1'b0; allAliensDead = 1'b0; playerHealth = 2'd3;
    tick(); tick();
    check("reset_state", int'(gameState), int'(IDLE));
    check("reset_enable", int'(gameplayEnable), 0);
    check("reset_levelResetN", int'(levelResetN), 1);
    check("reset_level", int'(level), 0);
    check("reset_hitFlash", int'(hitFlash), 0);
    resetN = 1'b1;

    // Start, hit, simultaneous lost+win (lost wins), animation entry
    for (int i = 0; i < 11; i++) begin
      startKey = vecs[i].startKey; lost = vecs[i].lost; allAliensDead = vecs[i].dead;
      playerHealth = vecs[i].health; startOfFrame = vecs[i].sof;
      tick();
      check($sformatf("vec%0d_state", i), int'(gameState), int'(vecs[i].st));
      check($sformatf("vec%0d_enable", i), int'(gameplayEnable), int'(vecs[i].en));
      check($sformatf("vec%0d_levelResetN", i), int'(levelResetN), int'(vecs[i].lrn));
      check($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].lvl));
      check($sformatf("vec%0d_hitFlash", i), int'(hitFlash), int'(vecs[i].hf));
    end
    lost = 1'b0; startOfFrame = 1'b0;

    // LOST_ANIM has seen 1 frame; 58 more keep it, the 60th leaves
    frames(58);
    check("lost_anim_59", int'(gameState), int'(LOST_ANIM));
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    check("lost_anim_60", int'(gameState), int'(GAME_OVER));
    tick();
    startKey = 1'b1; tick(); startKey = 1'b0;
    check("gameover_hold", int'(gameState), int'(GAME_OVER));
    tick();
    check("gameover_to_idle", int'(gameState), int'(IDLE));

    // Win loop through all levels, wrapping 7 -> 0
    startKey = 1'b1; tick(); startKey = 1'b0; tick();
    check("restart_state", int'(gameState), int'(PLAYING));
    check("restart_pulse", int'(levelResetN), 0);
    tick();
    for (int w = 0; w < 8; w++) begin
      expLvl = 3'((w + 1) % 8);
      allAliensDead = 1'b1; startOfFrame = 1'b1; tick();
      allAliensDead = 1'b0; startOfFrame = 1'b0;
      check($sformatf("win%0d_enter", w), int'(gameState), int'(WIN_ANIM));
      check($sformatf("win%0d_enable", w), int'(gameplayEnable), 0);
      tick();
      frames(59);
      check($sformatf("win%0d_59", w), int'(gameState), int'(WIN_ANIM));
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
      check($sformatf("win%0d_state", w), int'(gameState), int'(PLAYING));
      check($sformatf("win%0d_level", w), int'(level), int'(expLvl));
      check($sformatf("win%0d_pulse", w), int'(levelResetN), 0);
      tick();
      check($sformatf("win%0d_pulse_end", w), int'(levelResetN), 1);
      check($sformatf("win%0d_enable_on", w), int'(gameplayEnable), 1);
    end

    // Hit flash: 20 frames, then reload mid-way
    playerHealth = 2'd3; tick();
    check("health_up_ignored", int'(hitFlash), 0);
    playerHealth = 2'd2; tick();
    check("flash_start", int'(hitFlash), 1);
    frames(19);
    check("flash_19", int'(hitFlash), 1);
    frame();
    check("flash_20", int'(hitFlash), 0);
    playerHealth = 2'd3; tick();
    playerHealth = 2'd2; tick();
    check("flash2_start", int'(hitFlash), 1);
    frames(10);
    playerHealth = 2'd1; tick();
    frames(10);
    check("flash_reload_10", int'(hitFlash), 1);
    frames(9);
    check("flash_reload_19", int'(hitFlash), 1);
    frame();
    check("flash_reload_20", int'(hitFlash), 0);

    // Async reset mid-flash with start key held through it
    playerHealth = 2'd0; tick();
    check("flash_before_reset", int'(hitFlash), 1);
    startKey = 1'b1;
    #3 resetN = 1'b0;
    #1;
    check("async_reset_state", int'(gameState), int'(IDLE));
    check("async_reset_flash", int'(hitFlash), 0);
    check("async_reset_enable", int'(gameplayEnable), 0);
    check("async_reset_lrn", int'(levelResetN), 1);
    tick(); tick();
    resetN = 1'b1;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (levelResetN == 1'b0) lows++;
    end
    check("held_through_reset", int'(gameState), int'(IDLE));
    check("held_through_reset_pulses", lows, 0);
    startKey = 1'b0; tick(); tick();
    startKey = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (levelResetN == 1'b0) lows++;
    end
    check("held_100_state", int'(gameState), int'(PLAYING));
    check("held_100_pulses", lows, 1);
    startKey = 1'b0; playerHealth = 2'd3; tick();

`ifdef GAME_PAUSE_EN
    playerHealth = 2'd2; tick();
    frames(5);
    pauseKey = 1'b1; tick(); pauseKey = 1'b0; tick();
    check("pause_state", int'(gameState), int'(PAUSED));
    check("pause_enable", int'(gameplayEnable), 0);
    lost = 1'b1;
    frames(25);
    lost = 1'b0;
    check("pause_lost_ignored", int'(gameState), int'(PAUSED));
    check("pause_flash_frozen", int'(hitFlash), 1);
    pauseKey = 1'b1; tick();
    check("unpause_lrn_a", int'(levelResetN), 1);
    pauseKey = 1'b0; tick();
    check("unpause_state", int'(gameState), int'(PLAYING));
    check("unpause_lrn_b", int'(levelResetN), 1);
    check("unpause_enable", int'(gameplayEnable), 1);
    frames(14);
    check("unpause_flash_14", int'(hitFlash), 1);
    frame();
    check("unpause_flash_15", int'(hitFlash), 0);
`else
    pauseKey = 1'b1; tick(); pauseKey = 1'b0; tick(); tick(); tick();
    check("pause_disabled_state", int'(gameState), int'(PLAYING));
    check("pause_disabled_enable", int'(gameplayEnable), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
